// File: rtl/ste_snd_dma_ctrl.sv
// rtl/ste_snd_dma_ctrl.sv - STE DMA sound fetch sequencer with frame registers
module ste_snd_dma_ctrl #(
    parameter int LOAD_LEN = 4
) (
    input  logic        clk32,
    input  logic        resb,
    input  logic        CS,
    input  logic [3:0]  A,
    input  logic        RW,
    input  logic [15:0] DIN,
    output logic [15:0] DOUT,
    input  logic        SLOT,
    input  logic        SREQ,
    output logic        SLOAD_N,
    output logic [22:0] ADDR,
    output logic        ACTIVE,
    output logic        SINT
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FETCH = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  ctrl_q, ctrl_d;              // bit0 PLAY, bit1 LOOP
    logic [22:0] start_sh_q, start_sh_d;      // CPU-visible frame start (word address)
    logic [22:0] end_sh_q, end_sh_d;          // CPU-visible frame end (word address)
    logic [22:0] work_start_q, work_start_d;  // frame start in use by the sequencer
    logic [22:0] work_end_q, work_end_d;      // frame end in use by the sequencer
    logic [22:0] counter_q, counter_d;
    logic [22:0] addr_q, addr_d;
    logic [3:0]  load_cnt_q, load_cnt_d;
    logic        sint_q, sint_d;
    logic        cs_q;

    logic        wr_commit;
    logic        play_rise;
    logic        unused_din;

    // Writes land on the trailing edge of CS, when A/DIN are settled
    assign wr_commit  = cs_q && !CS && !RW;
    assign play_rise  = wr_commit && (A == 4'd0) && DIN[0] && !ctrl_q[0];
    assign unused_din = ^DIN[15:8];

    assign SLOAD_N = (state_q != S_FETCH);
    assign ACTIVE  = (state_q != S_IDLE);
    assign ADDR    = addr_q;
    assign SINT    = sint_q;

    // Register readback; the frame/counter registers expose byte-address fields
    always_comb begin
        DOUT = 16'h0000;
        case (A)
            4'd0:    DOUT = {14'd0, ctrl_q};
            4'd1:    DOUT = {8'd0, start_sh_q[22:15]};
            4'd2:    DOUT = {8'd0, start_sh_q[14:7]};
            4'd3:    DOUT = {8'd0, start_sh_q[6:0], 1'b0};
            4'd4:    DOUT = {8'd0, counter_q[22:15]};
            4'd5:    DOUT = {8'd0, counter_q[14:7]};
            4'd6:    DOUT = {8'd0, counter_q[6:0], 1'b0};
            4'd7:    DOUT = {8'd0, end_sh_q[22:15]};
            4'd8:    DOUT = {8'd0, end_sh_q[14:7]};
            4'd9:    DOUT = {8'd0, end_sh_q[6:0], 1'b0};
            default: DOUT = 16'h0000;
        endcase
    end

    // Register writes and fetch sequencing; sequencer updates to ctrl override the CPU
    always_comb begin
        state_d      = state_q;
        ctrl_d       = ctrl_q;
        start_sh_d   = start_sh_q;
        end_sh_d     = end_sh_q;
        work_start_d = work_start_q;
        work_end_d   = work_end_q;
        counter_d    = counter_q;
        addr_d       = addr_q;
        load_cnt_d   = load_cnt_q;
        sint_d       = 1'b0;

        if (wr_commit) begin
            case (A)
                4'd0: ctrl_d            = DIN[1:0];
                4'd1: start_sh_d[22:15] = DIN[7:0];
                4'd2: start_sh_d[14:7]  = DIN[7:0];
                4'd3: start_sh_d[6:0]   = DIN[7:1];
                4'd7: end_sh_d[22:15]   = DIN[7:0];
                4'd8: end_sh_d[14:7]    = DIN[7:0];
                4'd9: end_sh_d[6:0]     = DIN[7:1];
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (play_rise) begin
                    work_start_d = start_sh_q;
                    work_end_d   = end_sh_q;
                    counter_d    = start_sh_q;
                    if (start_sh_q >= end_sh_q) begin
                        // Empty frame: report it as finished without fetching
                        sint_d    = 1'b1;
                        ctrl_d[0] = 1'b0;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else if (SLOT && SREQ) begin
                    state_d    = S_FETCH;
                    addr_d     = counter_q;
                    load_cnt_d = 4'd0;
                end
            end
            S_FETCH: begin
                if (load_cnt_q == 4'(LOAD_LEN - 1)) begin
                    counter_d = counter_q + 23'd1;
                    state_d   = S_CHECK;
                end else begin
                    load_cnt_d = load_cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                if (counter_q == work_end_q) begin
                    sint_d = 1'b1;
                    if (ctrl_q[1]) begin
                        work_start_d = start_sh_q;
                        work_end_d   = end_sh_q;
                        counter_d    = start_sh_q;
                        state_d      = S_RUN;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = S_IDLE;
                    end
                end else if (!ctrl_q[0]) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and register update with synchronous reset
    always_ff @(posedge clk32) begin
        if (!resb) begin
            state_q      <= S_IDLE;
            ctrl_q       <= 2'd0;
            start_sh_q   <= '0;
            end_sh_q     <= '0;
            work_start_q <= '0;
            work_end_q   <= '0;
            counter_q    <= '0;
            addr_q       <= '0;
            load_cnt_q   <= 4'd0;
            sint_q       <= 1'b0;
            cs_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            start_sh_q   <= start_sh_d;
            end_sh_q     <= end_sh_d;
            work_start_q <= work_start_d;
            work_end_q   <= work_end_d;
            counter_q    <= counter_d;
            addr_q       <= addr_d;
            load_cnt_q   <= load_cnt_d;
            sint_q       <= sint_d;
            cs_q         <= CS;
        end
    end

endmodule

// File: tb/tb_ste_snd_dma_ctrl.sv
// tb/tb_ste_snd_dma_ctrl.sv - randomized bench for ste_snd_dma_ctrl against a behavioural model
module tb_ste_snd_dma_ctrl;

    localparam int LOAD_LEN = 4;

    logic        clk32 = 1'b0;
    logic        resb  = 1'b0;
    logic        CS    = 1'b0;
    logic [3:0]  A     = 4'd0;
    logic        RW    = 1'b1;
    logic [15:0] DIN   = 16'd0;
    logic        SLOT  = 1'b0;
    logic        SREQ  = 1'b0;
    logic [15:0] DOUT;
    logic        SLOAD_N;
    logic [22:0] ADDR;
    logic        ACTIVE;
    logic        SINT;

    always #5 clk32 = ~clk32;

    ste_snd_dma_ctrl #(.LOAD_LEN(LOAD_LEN)) dut (
        .clk32(clk32), .resb(resb), .CS(CS), .A(A), .RW(RW), .DIN(DIN),
        .DOUT(DOUT), .SLOT(SLOT), .SREQ(SREQ), .SLOAD_N(SLOAD_N),
        .ADDR(ADDR), .ACTIVE(ACTIVE), .SINT(SINT)
    );

    int checks = 0;
    int errors = 0;
    int slot_mode = 0;
    int slot_cyc = 0;

    // behavioural model: frame values held as word addresses
    logic [22:0] m_ss = '0, m_se = '0, m_ws = '0, m_we = '0, m_cnt = '0, m_addr = '0;
    logic        m_play = 1'b0, m_loop = 1'b0, m_active = 1'b0, m_chk = 1'b0;
    logic        m_sint = 1'b0, m_csp = 1'b0;
    int          m_left = 0;

    // observed fetch history
    logic [22:0] fq[$];
    int          lq[$];
    int          low_run = 0;
    int          sint_cnt = 0;
    int          act_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // byte-address view of a word address: sel 0=hi, 1=mid, 2=lo
    function automatic logic [15:0] field(input logic [22:0] w, input int sel);
        logic [23:0] b;
        b = {w, 1'b0};
        if (sel == 0) return {8'd0, b[23:16]};
        if (sel == 1) return {8'd0, b[15:8]};
        return {8'd0, b[7:0]};
    endfunction

    function automatic logic [15:0] m_rd(input logic [3:0] a);
        if (a == 4'd0) return {14'd0, m_loop, m_play};
        if (a >= 4'd1 && a <= 4'd3) return field(m_ss, int'(a) - 1);
        if (a >= 4'd4 && a <= 4'd6) return field(m_cnt, int'(a) - 4);
        if (a >= 4'd7 && a <= 4'd9) return field(m_se, int'(a) - 7);
        return 16'd0;
    endfunction

    function automatic logic [22:0] put_field(input logic [22:0] w, input int sel, input logic [7:0] v);
        logic [23:0] b;
        b = {w, 1'b0};
        if (sel == 0) b[23:16] = v;
        else if (sel == 1) b[15:8] = v;
        else b[7:0] = v;
        return b[23:1];
    endfunction

    task automatic step_model();
        logic       wr_en, o_play, o_loop;
        logic [22:0] o_ss, o_se;
        if (!resb) begin
            m_ss = '0; m_se = '0; m_ws = '0; m_we = '0; m_cnt = '0; m_addr = '0;
            m_play = 1'b0; m_loop = 1'b0; m_active = 1'b0; m_chk = 1'b0;
            m_sint = 1'b0; m_left = 0; m_csp = 1'b0;
            return;
        end
        wr_en  = m_csp && !CS && !RW;
        o_play = m_play;
        o_loop = m_loop;
        o_ss   = m_ss;
        o_se   = m_se;
        m_sint = 1'b0;
        if (wr_en) begin
            if (A == 4'd0) begin
                m_play = DIN[0];
                m_loop = DIN[1];
            end else if (A >= 4'd1 && A <= 4'd3) begin
                m_ss = put_field(m_ss, int'(A) - 1, DIN[7:0]);
            end else if (A >= 4'd7 && A <= 4'd9) begin
                m_se = put_field(m_se, int'(A) - 7, DIN[7:0]);
            end
        end
        if (!m_active) begin
            if (wr_en && A == 4'd0 && DIN[0] && !o_play) begin
                m_ws = o_ss; m_we = o_se; m_cnt = o_ss;
                if (o_ss >= o_se) begin
                    m_sint = 1'b1;
                    m_play = 1'b0;
                end else begin
                    m_active = 1'b1;
                end
            end
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_cnt = m_cnt + 23'd1;
                m_chk = 1'b1;
            end
        end else if (m_chk) begin
            m_chk = 1'b0;
            if (m_cnt == m_we) begin
                m_sint = 1'b1;
                if (o_loop) begin
                    m_ws = o_ss; m_we = o_se; m_cnt = o_ss;
                end else begin
                    m_play = 1'b0;
                    m_active = 1'b0;
                end
            end else if (!o_play) begin
                m_active = 1'b0;
            end
        end else begin
            if (!o_play) m_active = 1'b0;
            else if (SLOT && SREQ) begin
                m_left = LOAD_LEN;
                m_addr = m_cnt;
            end
        end
        m_csp = CS;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk32);
        CS = 1'b1; RW = 1'b0; A = a; DIN = d;
        @(negedge clk32);
        CS = 1'b0;
        @(negedge clk32);
        RW = 1'b1;
    endtask

    task automatic read_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
        @(negedge clk32);
        A = a;
        #1;
        check(name, 32'(DOUT), 32'(exp));
    endtask

    task automatic wait_active(input string name, input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if (ACTIVE === val) break;
        end
        check(name, 32'(ACTIVE), 32'(val));
    endtask

    task automatic wait_fetches(input string name, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk32);
            if (fq.size() >= n) break;
        end
        check(name, 32'(fq.size() >= n), 32'd1);
    endtask

    task automatic chk_fetch(input string name, input int idx, input logic [22:0] exp);
        if (idx < fq.size()) check(name, 32'(fq[idx]), 32'(exp));
        else check(name, 32'(fq.size()), 32'(idx + 1));
    endtask

    initial begin
        int base, s0, a0, r;
        logic [3:0] ra;
        logic [15:0] rd;

        fork
            forever begin
                @(posedge clk32);
                step_model();
                #2;
                check("sload_n", 32'(SLOAD_N), 32'(m_left == 0));
                check("active", 32'(ACTIVE), 32'(m_active));
                check("sint", 32'(SINT), 32'(m_sint));
                check("addr", 32'(ADDR), 32'(m_addr));
                check("dout", 32'(DOUT), 32'(m_rd(A)));
                if (SLOAD_N === 1'b0) begin
                    if (low_run == 0) fq.push_back(ADDR);
                    low_run++;
                end else if (low_run > 0) begin
                    lq.push_back(low_run);
                    low_run = 0;
                end
                if (SINT === 1'b1) sint_cnt++;
                if (ACTIVE === 1'b1) act_cnt++;
            end
            forever begin
                @(negedge clk32);
                slot_cyc++;
                if (slot_mode == 1) SLOT = (slot_cyc % 64 == 0);
                else if (slot_mode == 2) SLOT = ($urandom_range(0, 7) == 0);
                else SLOT = 1'b0;
            end
        join_none

        // reset state
        repeat (4) @(negedge clk32);
        #1;
        check("rst_sload_n", 32'(SLOAD_N), 32'd1);
        check("rst_active", 32'(ACTIVE), 32'd0);
        check("rst_ctrl", 32'(DOUT), 32'd0);
        resb = 1'b1;

        // one-shot frame 0x010000..0x010006
        slot_mode = 1;
        SREQ = 1'b1;
        wr(4'd1, 16'h0001); wr(4'd2, 16'h0000); wr(4'd3, 16'h0000);
        wr(4'd7, 16'h0001); wr(4'd8, 16'h0000); wr(4'd9, 16'h0006);
        base = fq.size(); s0 = sint_cnt;
        wr(4'd0, 16'h0001);
        wait_active("oneshot_done", 1'b0, 400);
        check("oneshot_nfetch", 32'(fq.size() - base), 32'd3);
        chk_fetch("oneshot_f0", base, 23'h008000);
        chk_fetch("oneshot_f1", base + 1, 23'h008001);
        chk_fetch("oneshot_f2", base + 2, 23'h008002);
        for (int i = 0; i < 3 && i < lq.size(); i++)
            check("oneshot_len", 32'(lq[lq.size() - 1 - i]), 32'(LOAD_LEN));
        check("oneshot_sint", 32'(sint_cnt - s0), 32'd1);
        read_chk("oneshot_ctrl", 4'd0, 16'h0000);
        read_chk("oneshot_cnt_lo", 4'd6, 16'h0006);
        read_chk("oneshot_cnt_hi", 4'd4, 16'h0001);

        // loop with start rewritten mid-frame
        base = fq.size(); s0 = sint_cnt;
        wr(4'd0, 16'h0003);
        wait_fetches("loop_first", base + 1, 200);
        repeat (10) @(negedge clk32);
        wr(4'd1, 16'h0002);
        wait_fetches("loop_fourth", base + 4, 400);
        chk_fetch("loop_f1", base + 1, 23'h008001);
        chk_fetch("loop_f2", base + 2, 23'h008002);
        chk_fetch("loop_f3", base + 3, 23'h010000);
        check("loop_sint", 32'(sint_cnt - s0), 32'd1);
        check("loop_active", 32'(ACTIVE), 32'd1);
        wr(4'd0, 16'h0000);
        wait_active("loop_stop", 1'b0, 50);

        // reset in the middle of a fetch
        wr(4'd1, 16'h0001);
        base = fq.size();
        wr(4'd0, 16'h0001);
        wait_fetches("midrst_fetch", base + 1, 200);
        resb = 1'b0;
        @(negedge clk32);
        resb = 1'b1;
        #1;
        check("midrst_sload_n", 32'(SLOAD_N), 32'd1);
        check("midrst_active", 32'(ACTIVE), 32'd0);
        read_chk("midrst_ctrl", 4'd0, 16'h0000);
        read_chk("midrst_cnt_hi", 4'd4, 16'h0000);
        read_chk("midrst_cnt_mid", 4'd5, 16'h0000);
        read_chk("midrst_cnt_lo", 4'd6, 16'h0000);
        read_chk("midrst_start_hi", 4'd1, 16'h0000);

        // SREQ low holds off fetches
        wr(4'd1, 16'h0004); wr(4'd2, 16'h0000); wr(4'd3, 16'h0000);
        wr(4'd7, 16'h0004); wr(4'd8, 16'h0001); wr(4'd9, 16'h0000);
        SREQ = 1'b0;
        base = fq.size();
        wr(4'd0, 16'h0001);
        repeat (200) @(negedge clk32);
        check("sreq0_nofetch", 32'(fq.size() - base), 32'd0);
        read_chk("sreq0_cnt_lo", 4'd6, 16'h0000);
        read_chk("sreq0_cnt_hi", 4'd4, 16'h0004);
        check("sreq0_active", 32'(ACTIVE), 32'd1);
        SREQ = 1'b1;
        wait_fetches("sreq1_resume", base + 1, 100);
        chk_fetch("sreq1_addr", base, 23'h020000);

        // PLAY cleared while SLOAD_N is low
        wait_fetches("stop_fetch", base + 2, 100);
        chk_fetch("stop_addr", base + 1, 23'h020001);
        s0 = sint_cnt;
        wr(4'd0, 16'h0000);
        wait_active("stop_idle", 1'b0, 20);
        if (lq.size() > 0) check("stop_len", 32'(lq[lq.size() - 1]), 32'(LOAD_LEN));
        else check("stop_len_missing", 32'(lq.size()), 32'd1);
        check("stop_nfetch", 32'(fq.size() - base), 32'd2);
        check("stop_sint", 32'(sint_cnt - s0), 32'd0);
        read_chk("stop_cnt_lo", 4'd6, 16'h0004);

        // empty frame with LOOP set
        wr(4'd1, 16'h0003); wr(4'd2, 16'h0000); wr(4'd3, 16'h0000);
        wr(4'd7, 16'h0003); wr(4'd8, 16'h0000); wr(4'd9, 16'h0000);
        base = fq.size(); s0 = sint_cnt; a0 = act_cnt;
        wr(4'd0, 16'h0003);
        repeat (100) @(negedge clk32);
        check("empty_nfetch", 32'(fq.size() - base), 32'd0);
        check("empty_sint", 32'(sint_cnt - s0), 32'd1);
        check("empty_active", 32'(act_cnt - a0), 32'd0);
        read_chk("empty_ctrl", 4'd0, 16'h0002);

        // randomized traffic, checked by the per-cycle model comparison
        slot_mode = 2;
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk32);
            SREQ = ($urandom_range(0, 3) != 0);
            A = 4'($urandom_range(0, 15));
            r = $urandom_range(0, 99);
            if (r < 4) begin
                rd = {8'($urandom_range(0, 255)), 8'd0};
                case ($urandom_range(0, 7))
                    0: begin ra = 4'd0; rd[1:0] = 2'($urandom_range(0, 3)); end
                    1: begin ra = 4'd1; rd[7:0] = 8'h05; end
                    2: begin ra = 4'd2; rd[7:0] = 8'($urandom_range(0, 1)); end
                    3: begin ra = 4'd3; rd[7:0] = 8'($urandom_range(0, 255)); end
                    4: begin ra = 4'd7; rd[7:0] = 8'h05; end
                    5: begin ra = 4'd8; rd[7:0] = 8'($urandom_range(0, 1)); end
                    6: begin ra = 4'd9; rd[7:0] = 8'($urandom_range(0, 255)); end
                    default: begin ra = 4'($urandom_range(0, 15)); rd = 16'($urandom); end
                endcase
                wr(ra, rd);
            end else if (r == 4 && $urandom_range(0, 9) == 0) begin
                resb = 1'b0;
                @(negedge clk32);
                resb = 1'b1;
            end
        end

        slot_mode = 0;
        repeat (5) @(negedge clk32);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
